aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_round_sched.sv | 181 ++++++++++++++++++
 tb/tb_aes_round_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 round scheduler.
package aes_pkg;

  localparam int NB    = 4;
  localparam int WORD  = 8;
  localparam int BLK_W = NB * NB * WORD;
  localparam int NR    = 10;

  typedef logic [BLK_W-1:0] blk_t;
  typedef logic [3:0]       rnd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } aes_sched_state_t;

endpackage

// File: rtl/aes_round_sched.sv
// AES-128 round scheduler: initial AddRoundKey, then NR rounds through an external datapath.
// Optional macro AES_ROUND_TIMEOUT_EN adds a per-round response timeout reported on o_err.
module aes_round_sched #(
  parameter int NB      = 4,
  parameter int WORD    = 8,
  parameter int NR      = 10,
  parameter int RND_TMO = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [NB*NB*WORD-1:0]  i_block,
  output logic [3:0]             rk_idx,
  input  logic [NB*NB*WORD-1:0]  rk,
  output logic                   dp_valid,
  output logic [NB*NB*WORD-1:0]  dp_block,
  output logic                   dp_last,
  input  logic                   dp_o_valid,
  input  logic [NB*NB*WORD-1:0]  dp_o_block,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [NB*NB*WORD-1:0]  o_block,
  output logic                   o_err
);

  import aes_pkg::*;

  localparam int   BW       = NB * NB * WORD;
  localparam rnd_t LAST_RND = rnd_t'(NR);

  aes_sched_state_t state_q, state_d;
  rnd_t             round_q, round_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             rdy_q, rdy_d;
  logic             dpv_q, dpv_d;
  logic             last_q, last_d;
  logic             ov_q, ov_d;
  logic [3:0]       idx_q, idx_d;
  logic             err_d;

`ifdef AES_ROUND_TIMEOUT_EN
  localparam int TW = $clog2(RND_TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q;
`endif

  // Next-state, round counter and state-register update.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;
    err_d   = 1'b0;
`ifdef AES_ROUND_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid && rdy_q) begin
          blk_d   = i_block ^ rk;
          round_d = 4'd1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef AES_ROUND_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (dp_o_valid) begin
          blk_d = dp_o_block;
          if (round_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end else begin
`ifdef AES_ROUND_TIMEOUT_EN
          if (tmo_q == TW'(RND_TMO - 1)) begin
            state_d = IDLE;
            round_d = '0;
            blk_d   = '0;
            err_d   = 1'b1;
          end else begin
            tmo_d   = tmo_q + TW'(1);
          end
`else
          state_d = WAIT;
`endif
        end
      end
      DONE: begin
        if (o_ready) begin
          state_d = IDLE;
          round_d = '0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    rdy_d = (state_d == IDLE);
    dpv_d = (state_d == ISSUE);
    ov_d  = (state_d == DONE);
    if (state_d == IDLE) begin
      idx_d  = '0;
      last_d = 1'b0;
    end else if (state_d == DONE) begin
      idx_d  = round_d;
      last_d = 1'b0;
    end else begin
      idx_d  = round_d;
      last_d = (round_d == LAST_RND);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      blk_q   <= '0;
      rdy_q   <= 1'b0;
      dpv_q   <= 1'b0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      rdy_q   <= rdy_d;
      dpv_q   <= dpv_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      idx_q   <= idx_d;
    end
  end

`ifdef AES_ROUND_TIMEOUT_EN
  // Per-round timeout counter and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  // No timeout hardware in this build; RND_TMO stays in the interface for both builds.
  logic unused_tmo;
  assign unused_tmo = ^{RND_TMO, err_d};
  assign o_err      = 1'b0;
`endif

  assign i_ready  = rdy_q;
  assign rk_idx   = idx_q;
  assign dp_valid = dpv_q;
  assign dp_last  = last_q;
  assign dp_block = blk_q;
  assign o_valid  = ov_q;
  assign o_block  = blk_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Scoreboard bench for aes_round_sched: a behavioural AES-128 model acts as key store,
// round datapath and reference; a monitor checks outputs against queued expectations.
module tb_aes_round_sched;

  localparam int NR = 10;
`ifdef AES_ROUND_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, i_ready, dp_valid, dp_last, dp_o_valid, o_valid, o_ready, o_err;
  logic [127:0] i_block, rk, dp_block, dp_o_block, o_block;
  logic [3:0]   rk_idx;

  logic [127:0] rkeys [16];
  logic [7:0]   sbox  [256];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  int           dp_lat = 1;
  bit           hang_en = 1'b0;
  logic [3:0]   hang_rnd = 4'd3;
  bit           spur = 1'b0;
  logic [127:0] spur_blk = 128'd0;
  bit           force_bp = 1'b0;

  typedef struct {
    logic [127:0] blk;
    int           acc;
    int           lat;
  } exp_t;
  exp_t sb[$];

  aes_round_sched dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_block    (i_block),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .dp_valid   (dp_valid),
    .dp_block   (dp_block),
    .dp_last    (dp_last),
    .dp_o_valid (dp_o_valid),
    .dp_o_block (dp_o_block),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_block    (o_block),
    .o_err      (o_err)
  );

  // Key store: combinational lookup of the expanded schedule.
  assign rk = rkeys[rk_idx];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = {inv[6:0], inv[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rkeys[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
  endtask

  // One AES round on a column-major state (byte 0 in the MSBs).
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end else begin
      for (int i = 0; i < 16; i++) a[i] = b[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= NR; r++) s = aes_rnd(s, rkeys[r], r == NR);
    return s;
  endfunction

  // Round datapath model with configurable latency; can be told to never answer a round.
  initial begin : dp_model
    logic [127:0] res;
    dp_o_valid = 1'b0;
    dp_o_block = 128'd0;
    forever begin
      @(posedge clk); #1;
      dp_o_valid = spur;
      dp_o_block = spur ? spur_blk : rnd128();
      while (dp_valid) begin
        if (hang_en && rk_idx == hang_rnd) begin
          @(posedge clk); #1;
        end else begin
          res = aes_rnd(dp_block, rk, dp_last);
          repeat (dp_lat) @(posedge clk);
          #1;
          dp_o_valid = 1'b1;
          dp_o_block = res;
          @(posedge clk); #1;
          dp_o_valid = 1'b0;
          dp_o_block = rnd128();
        end
      end
    end
  end

  // Consumer: random readiness unless backpressure is forced.
  initial begin : consumer
    o_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      o_ready = force_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: round sequencing, output stability, scoreboard compare and latency.
  initial begin : monitor
    int           cnt;
    int           ov_cyc;
    bit           ov_p, or_p, chk_rdy;
    logic [127:0] ob_p;
    exp_t         e;
    cnt = 0; ov_cyc = 0; ov_p = 1'b0; or_p = 1'b0; chk_rdy = 1'b0; ob_p = 128'd0;
    forever begin
      @(negedge clk);
      if (rst || o_err) begin
        cnt = 0; ov_p = 1'b0; or_p = 1'b0; chk_rdy = 1'b0;
      end else begin
        if (i_valid && i_ready) check("rk_idx_idle", 128'(rk_idx), 128'd0);
        if (dp_valid) begin
          cnt++;
          check("rk_idx_seq", 128'(rk_idx), 128'(cnt));
          check("dp_last", 128'(dp_last), 128'(cnt == NR));
        end
        if (ov_p && !or_p) begin
          check("o_valid_hold", 128'(o_valid), 128'd1);
          check("o_block_hold", o_block, ob_p);
        end
        if (o_valid && !ov_p) ov_cyc = cyc;
        if (o_valid && o_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 128'd1, 128'd0);
          end else begin
            e = sb.pop_front();
            check("o_block", o_block, e.blk);
            check("o_valid_latency", 128'(ov_cyc - e.acc), 128'(NR * (e.lat + 1) + 1));
            check("dp_valid_count", 128'(cnt), 128'(NR));
          end
          cnt = 0;
          chk_rdy = 1'b1;
        end else if (chk_rdy) begin
          check("i_ready_after_hs", 128'(i_ready), 128'd1);
          chk_rdy = 1'b0;
        end
        ov_p = o_valid;
        or_p = o_ready;
        ob_p = o_block;
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] expv, input int lat_i);
    int n;
    n = 0;
    dp_lat = lat_i;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_block = pt;
    @(negedge clk);
    while (!i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!i_ready) begin
      check("accept_timeout", 128'd0, 128'd1);
      i_valid = 1'b0;
      return;
    end
    sb.push_back('{blk: expv, acc: cyc, lat: lat_i});
    // Junk offers while busy must be ignored.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      i_valid = 1'($urandom_range(0, 1));
      i_block = rnd128();
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("block_done_timeout", 128'(sb.size()), 128'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_i_ready"},  128'(i_ready),  128'd0);
    check({tag, "_dp_valid"}, 128'(dp_valid), 128'd0);
    check({tag, "_o_valid"},  128'(o_valid),  128'd0);
    check({tag, "_o_err"},    128'(o_err),    128'd0);
    check({tag, "_dp_last"},  128'(dp_last),  128'd0);
    check({tag, "_rk_idx"},   128'(rk_idx),   128'd0);
    check({tag, "_o_block"},  o_block,        128'd0);
    check({tag, "_dp_block"}, dp_block,       128'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish by 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [127:0] pt, ob0;
    int           n;
    rst = 1'b1;
    i_valid = 1'b0;
    i_block = 128'd0;
    build_sbox();
    expand(128'h000102030405060708090a0b0c0d0e0f);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("i_ready_before_edge", 128'(i_ready), 128'd0);
    @(negedge clk);
    check("i_ready_first_edge", 128'(i_ready), 128'd1);

    // Known-answer block.
    send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1);
    wait_done();

    // Spurious datapath result while idle.
    ob0 = o_block;
    spur_blk = rnd128();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("spur_o_block", o_block, ob0);
      check("spur_o_valid", 128'(o_valid), 128'd0);
      check("spur_dp_valid", 128'(dp_valid), 128'd0);
      check("spur_i_ready", 128'(i_ready), 128'd1);
    end

    // Backpressure: consumer holds off for five cycles.
    expand(rnd128());
    pt = rnd128();
    force_bp = 1'b1;
    send(pt, aes_ref(pt), 2);
    n = 0;
    while (!o_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("bp_o_valid_seen", 128'(o_valid), 128'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_o_valid", 128'(o_valid), 128'd1);
      check("bp_i_ready", 128'(i_ready), 128'd0);
      check("bp_o_block", o_block, aes_ref(pt));
    end
    force_bp = 1'b0;
    wait_done();

    // Random keys, plaintexts and datapath latencies.
    for (int b = 0; b < 8; b++) begin
      expand(rnd128());
      pt = rnd128();
      send(pt, aes_ref(pt), int'($urandom_range(1, 3)));
      wait_done();
    end

    // Reset during the WAIT of round 5.
    expand(rnd128());
    pt = rnd128();
    send(pt, aes_ref(pt), 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dp_valid && rk_idx == 4'd5) && n < 200);
    check("round5_issue_seen", 128'(rk_idx), 128'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_dp_valid", 128'(dp_valid), 128'd0);
      check("post_rst_o_valid", 128'(o_valid), 128'd0);
    end
    pt = rnd128();
    send(pt, aes_ref(pt), 2);
    wait_done();

    // Datapath never answers round 3; a stray offer arrives mid-WAIT.
    expand(rnd128());
    pt = rnd128();
    hang_en = 1'b1;
    send(pt, aes_ref(pt), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dp_valid && rk_idx == 4'd3) && n < 200);
    check("round3_issue_seen", 128'(rk_idx), 128'd3);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        i_valid = 1'b1;
        i_block = rnd128();
      end else begin
        i_valid = 1'b0;
      end
      check("hang_o_err", 128'(o_err), 128'(TMO_EN && k == 17));
      check("hang_i_ready", 128'(i_ready), 128'(TMO_EN && k >= 17));
      check("hang_o_valid", 128'(o_valid), 128'd0);
      check("hang_dp_valid", 128'(dp_valid), 128'd0);
      check("hang_rk_idx", 128'(rk_idx), (TMO_EN && k >= 17) ? 128'd0 : 128'd3);
    end
    i_valid = 1'b0;
    hang_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    pt = rnd128();
    send(pt, aes_ref(pt), 1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
